// File: rtl/coin_accumulator.sv
// rtl/coin_accumulator.sv - coin crediting, vend arbitration and greedy change dispenser
// Optional idle auto-refund is built only when COIN_TIMEOUT_EN is defined.
module coin_accumulator #(
  parameter int                         NUM_COINS   = 4,
  parameter int                         BAL_W       = 8,
  parameter logic [NUM_COINS*BAL_W-1:0] COIN_VALS   = {8'd50, 8'd20, 8'd10, 8'd5},
  parameter int                         TIMEOUT_CYC = 1000000
) (
  input  logic                                                 clk,
  input  logic                                                 reset_n,
  input  logic [NUM_COINS-1:0]                                 coin_in,
  output logic                                                 coin_accept,
  output logic                                                 coin_reject,
  input  logic [BAL_W-1:0]                                     price,
  input  logic                                                 vend_req,
  input  logic                                                 cancel,
  output logic                                                 vend_ok,
  output logic                                                 vend_deny,
  output logic                                                 chg_valid,
  output logic [((NUM_COINS > 1) ? $clog2(NUM_COINS) : 1)-1:0] chg_idx,
  input  logic                                                 chg_ready,
  output logic [BAL_W-1:0]                                     balance,
  output logic                                                 busy,
  output logic                                                 timeout_evt
);

  localparam int IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1;

  typedef enum logic {S_IDLE, S_CHANGE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BAL_W-1:0]   r_balance;
  logic [BAL_W-1:0]   w_bal_nxt;
  logic               r_accept, r_reject, r_vend_ok, r_vend_deny, r_timeout_evt;
  logic               w_accept, w_reject, w_vend_ok, w_vend_deny, w_timeout;
  logic               r_chg_valid;
  logic [IDX_W-1:0]   r_chg_idx;
  logic               w_coin_any;
  logic               w_coin_multi;
  logic [BAL_W-1:0]   w_coin_val;
  logic [BAL_W:0]     w_coin_sum;
  logic [BAL_W-1:0]   w_bal_after_chg;
  logic               w_tmo_hit;

  // value of coin channel idx
  function automatic logic [BAL_W-1:0] f_val(input logic [IDX_W-1:0] idx);
    f_val = '0;
    for (int i = 0; i < NUM_COINS; i++)
      if (idx == IDX_W'(i)) f_val = COIN_VALS[i*BAL_W +: BAL_W];
  endfunction

  // true when at least one coin value can be paid out of bal
  function automatic logic f_fits(input logic [BAL_W-1:0] bal);
    f_fits = 1'b0;
    for (int i = 0; i < NUM_COINS; i++)
      if (COIN_VALS[i*BAL_W +: BAL_W] <= bal) f_fits = 1'b1;
  endfunction

  // largest coin not exceeding bal; strict '>' keeps the lowest index on ties
  function automatic logic [IDX_W-1:0] f_best_idx(input logic [BAL_W-1:0] bal);
    logic             found;
    logic [BAL_W-1:0] best_v;
    logic [BAL_W-1:0] v;
    found      = 1'b0;
    best_v     = '0;
    f_best_idx = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      v = COIN_VALS[i*BAL_W +: BAL_W];
      if ((v <= bal) && (!found || (v > best_v))) begin
        found      = 1'b1;
        best_v     = v;
        f_best_idx = IDX_W'(i);
      end
    end
  endfunction

  assign w_coin_any      = |coin_in;
  assign w_coin_multi    = ($countones(coin_in) > 1);
  assign w_coin_sum      = {1'b0, r_balance} + {1'b0, w_coin_val};
  assign w_bal_after_chg = r_balance - f_val(r_chg_idx);

  // value of the (single) coin being inserted this cycle
  always_comb begin
    w_coin_val = '0;
    for (int i = 0; i < NUM_COINS; i++)
      if (coin_in[i]) w_coin_val = w_coin_val | COIN_VALS[i*BAL_W +: BAL_W];
  end

  // next-state, balance update and pulse decisions
  always_comb begin
    w_state_nxt = r_state;
    w_bal_nxt   = r_balance;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_vend_ok   = 1'b0;
    w_vend_deny = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cancel) begin
          w_reject = w_coin_any;
          if (r_balance != '0) w_state_nxt = S_CHANGE;
        end else if (vend_req) begin
          w_reject = w_coin_any;
          if ((price != '0) && (r_balance >= price)) begin
            w_vend_ok = 1'b1;
            w_bal_nxt = r_balance - price;
            if (r_balance != price) w_state_nxt = S_CHANGE;
          end else begin
            w_vend_deny = 1'b1;
          end
        end else if (w_tmo_hit && (r_balance != '0)) begin
          // auto-refund behaves like cancel, so a coin arriving now is refused
          w_timeout   = 1'b1;
          w_reject    = w_coin_any;
          w_state_nxt = S_CHANGE;
        end else if (w_coin_any) begin
          if (w_coin_multi || w_coin_sum[BAL_W]) begin
            w_reject = 1'b1;
          end else begin
            w_accept  = 1'b1;
            w_bal_nxt = w_coin_sum[BAL_W-1:0];
          end
        end
      end
      S_CHANGE: begin
        w_reject = w_coin_any;
        // entered with a residual smaller than any coin: nothing to pay out
        if (!r_chg_valid) begin
          w_state_nxt = S_IDLE;
        end else if (chg_ready) begin
          w_bal_nxt = w_bal_after_chg;
          if (!f_fits(w_bal_after_chg)) w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

`ifdef COIN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_idle_cnt;

  assign w_tmo_hit = (r_idle_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // idle counter: runs while credit sits unused in IDLE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle_cnt <= '0;
    end else if ((r_state == S_IDLE) && (w_state_nxt == S_IDLE) && (r_balance != '0) &&
                 !w_accept && !w_vend_ok && !w_vend_deny) begin
      r_idle_cnt <= r_idle_cnt + CNT_W'(1);
    end else begin
      r_idle_cnt <= '0;
    end
  end
`else
  logic w_unused_timeout;

  assign w_tmo_hit        = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYC > 1);
`endif

  // state, balance and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_balance     <= '0;
      r_accept      <= 1'b0;
      r_reject      <= 1'b0;
      r_vend_ok     <= 1'b0;
      r_vend_deny   <= 1'b0;
      r_timeout_evt <= 1'b0;
      r_chg_valid   <= 1'b0;
      r_chg_idx     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_balance     <= w_bal_nxt;
      r_accept      <= w_accept;
      r_reject      <= w_reject;
      r_vend_ok     <= w_vend_ok;
      r_vend_deny   <= w_vend_deny;
      r_timeout_evt <= w_timeout;
      // index derives from the balance, so it holds while the hopper stalls
      r_chg_valid   <= (w_state_nxt == S_CHANGE) && f_fits(w_bal_nxt);
      r_chg_idx     <= f_best_idx(w_bal_nxt);
    end
  end

  assign coin_accept = r_accept;
  assign coin_reject = r_reject;
  assign vend_ok     = r_vend_ok;
  assign vend_deny   = r_vend_deny;
  assign chg_valid   = r_chg_valid;
  assign chg_idx     = r_chg_idx;
  assign balance     = r_balance;
  assign busy        = (r_state == S_CHANGE);
  assign timeout_evt = r_timeout_evt;

endmodule

// File: tb/tb_coin_accumulator.sv
// tb/tb_coin_accumulator.sv - self-checking bench for coin_accumulator
module tb_coin_accumulator;

  localparam int T_CYC = 16;
`ifdef COIN_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] coin_in;
  logic       coin_accept, coin_reject;
  logic [7:0] price;
  logic       vend_req, cancel;
  logic       vend_ok, vend_deny;
  logic       chg_valid;
  logic [1:0] chg_idx;
  logic       chg_ready;
  logic [7:0] balance;
  logic       busy, timeout_evt;

  always #5 clk = ~clk;

  coin_accumulator #(
    .NUM_COINS  (4),
    .BAL_W      (8),
    .COIN_VALS  ({8'd50, 8'd20, 8'd10, 8'd5}),
    .TIMEOUT_CYC(T_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .coin_in    (coin_in),
    .coin_accept(coin_accept),
    .coin_reject(coin_reject),
    .price      (price),
    .vend_req   (vend_req),
    .cancel     (cancel),
    .vend_ok    (vend_ok),
    .vend_deny  (vend_deny),
    .chg_valid  (chg_valid),
    .chg_idx    (chg_idx),
    .chg_ready  (chg_ready),
    .balance    (balance),
    .busy       (busy),
    .timeout_evt(timeout_evt)
  );

  int checks = 0;
  int errors = 0;
  int vals [4] = '{5, 10, 20, 50};

  typedef struct {
    logic [3:0] coin;
    int         price;
    bit         vend, cxl, rdy;
    bit         acc, rej, vok, vden, cv;
    int         idx;
    int         bal;
    bit         bsy;
  } vec_t;

  vec_t tbl[$];

  // reference model state: credit, refund plan, idle count
  int m_bal;
  int m_idle;
  bit m_busy;
  int m_q[$];

  function automatic void add(input logic [3:0] c, input int p, input bit v, input bit x, input bit r,
                              input bit acc, input bit rej, input bit vok, input bit vden,
                              input bit cv, input int idx, input int bal, input bit bsy);
    vec_t e;
    e.coin = c; e.price = p; e.vend = v; e.cxl = x; e.rdy = r;
    e.acc = acc; e.rej = rej; e.vok = vok; e.vden = vden;
    e.cv = cv; e.idx = idx; e.bal = bal; e.bsy = bsy;
    tbl.push_back(e);
  endfunction

  function automatic logic [17:0] got_vec();
    logic [1:0] gi;
    gi = chg_valid ? chg_idx : 2'd0;
    return {coin_accept, coin_reject, vend_ok, vend_deny, chg_valid, gi, balance, busy, timeout_evt};
  endfunction

  function automatic logic [17:0] pack(input bit acc, input bit rej, input bit vok, input bit vden,
                                       input bit cv, input int idx, input int bal, input bit bsy,
                                       input bit tev);
    logic [1:0] pi;
    pi = cv ? 2'(idx) : 2'd0;
    return {acc, rej, vok, vden, cv, pi, 8'(bal), bsy, tev};
  endfunction

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  // plan the whole refund up front: greedy largest coin, lowest index on ties
  task automatic start_refund();
    int b;
    int best;
    m_q.delete();
    b = m_bal;
    forever begin
      best = -1;
      for (int i = 0; i < 4; i++)
        if (vals[i] <= b && (best < 0 || vals[i] > vals[best])) best = i;
      if (best < 0) break;
      m_q.push_back(best);
      b -= vals[best];
    end
    m_busy = 1'b1;
  endtask

  task automatic model_step(input logic [3:0] c, input int p, input bit v, input bit x, input bit r,
                            output logic [17:0] e);
    bit acc, rej, vok, vden, tev, cv;
    int idx, ob, cval;
    acc = 0; rej = 0; vok = 0; vden = 0; tev = 0;
    ob = m_bal;
    if (!m_busy) begin
      if (x) begin
        rej = (c != 0);
        if (m_bal > 0) start_refund();
        m_idle = 0;
      end else if (v) begin
        rej = (c != 0);
        if (p != 0 && m_bal >= p) begin
          vok = 1;
          m_bal -= p;
          if (m_bal > 0) start_refund();
        end else begin
          vden = 1;
        end
        m_idle = 0;
      end else if (TMO && m_bal > 0 && m_idle == T_CYC - 1) begin
        tev = 1;
        rej = (c != 0);
        start_refund();
        m_idle = 0;
      end else if (c != 0 && $countones(c) == 1) begin
        cval = 0;
        for (int i = 0; i < 4; i++) if (c[i]) cval = vals[i];
        if (m_bal + cval > 255) begin
          rej = 1;
          m_idle = (ob > 0) ? m_idle + 1 : 0;
        end else begin
          acc = 1;
          m_bal += cval;
          m_idle = 0;
        end
      end else begin
        rej = (c != 0);
        m_idle = (ob > 0) ? m_idle + 1 : 0;
      end
    end else begin
      rej = (c != 0);
      m_idle = 0;
      if (m_q.size() == 0) begin
        m_busy = 1'b0;
      end else if (r) begin
        m_bal -= vals[m_q.pop_front()];
        if (m_q.size() == 0) m_busy = 1'b0;
      end
    end
    cv  = m_busy && (m_q.size() > 0);
    idx = cv ? m_q[0] : 0;
    e = pack(acc, rej, vok, vden, cv, idx, m_bal, m_busy, tev);
  endtask

  task automatic clear_inputs();
    coin_in = 4'd0; price = 8'd0; vend_req = 1'b0; cancel = 1'b0; chg_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_bal = 0; m_idle = 0; m_busy = 1'b0; m_q.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] e;
  int          n;
  bit          seen;
  int          r;

  initial begin
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", got_vec(), 18'd0);
    reset_n = 1'b1;

    //  coin  price vend cxl rdy | acc rej vok vden cv idx bal busy
    add(4'b0010,  0, 0, 0, 0,  1, 0, 0, 0,  0, 0,  10, 0);
    add(4'b0100,  0, 0, 0, 0,  1, 0, 0, 0,  0, 0,  30, 0);
    add(4'b0001,  0, 0, 0, 0,  1, 0, 0, 0,  0, 0,  35, 0);
    add(4'b0000, 25, 1, 0, 0,  0, 0, 1, 0,  1, 1,  10, 1);
    add(4'b0000,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0,   0, 0);
    for (int k = 1; k <= 5; k++)
      add(4'b1000, 0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 50 * k, 0);
    add(4'b0010,  0, 0, 0, 0,  0, 1, 0, 0,  0, 0, 250, 0);
    add(4'b0001,  0, 0, 0, 0,  1, 0, 0, 0,  0, 0, 255, 0);
    add(4'b0100,  0, 0, 1, 0,  0, 1, 0, 0,  1, 3, 255, 1);
    add(4'b0001,  5, 1, 0, 1,  0, 1, 0, 0,  1, 3, 205, 1);
    add(4'b0000,  0, 0, 0, 1,  0, 0, 0, 0,  1, 3, 155, 1);
    add(4'b0000,  0, 0, 0, 1,  0, 0, 0, 0,  1, 3, 105, 1);
    add(4'b0000,  0, 0, 0, 1,  0, 0, 0, 0,  1, 3,  55, 1);
    add(4'b0000,  0, 0, 0, 1,  0, 0, 0, 0,  1, 0,   5, 1);
    add(4'b0000,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0,   0, 0);
    add(4'b0100,  0, 0, 0, 0,  1, 0, 0, 0,  0, 0,  20, 0);
    add(4'b0010,  0, 0, 0, 0,  1, 0, 0, 0,  0, 0,  30, 0);
    add(4'b0001,  0, 0, 0, 0,  1, 0, 0, 0,  0, 0,  35, 0);
    add(4'b0000, 40, 1, 0, 0,  0, 0, 0, 1,  0, 0,  35, 0);
    add(4'b0011,  0, 0, 0, 0,  0, 1, 0, 0,  0, 0,  35, 0);
    add(4'b0000,  0, 1, 0, 0,  0, 0, 0, 1,  0, 0,  35, 0);
    add(4'b1100,  0, 0, 0, 0,  0, 1, 0, 0,  0, 0,  35, 0);
    add(4'b0100,  0, 0, 0, 0,  1, 0, 0, 0,  0, 0,  55, 0);
    add(4'b0100,  0, 0, 0, 0,  1, 0, 0, 0,  0, 0,  75, 0);
    add(4'b0000,  0, 0, 1, 0,  0, 0, 0, 0,  1, 3,  75, 1);
    add(4'b0000,  0, 0, 0, 0,  0, 0, 0, 0,  1, 3,  75, 1);
    add(4'b0000,  0, 0, 0, 0,  0, 0, 0, 0,  1, 3,  75, 1);
    add(4'b0000,  0, 0, 0, 0,  0, 0, 0, 0,  1, 3,  75, 1);
    add(4'b0000,  0, 0, 0, 1,  0, 0, 0, 0,  1, 2,  25, 1);
    add(4'b0000,  0, 0, 0, 1,  0, 0, 0, 0,  1, 0,   5, 1);
    add(4'b0000,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0,   0, 0);
    add(4'b0010,  0, 0, 0, 0,  1, 0, 0, 0,  0, 0,  10, 0);
    add(4'b0001,  7, 1, 0, 0,  0, 1, 1, 0,  0, 0,   3, 1);
    add(4'b0000,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0,   3, 0);
    add(4'b0001,  0, 0, 0, 0,  1, 0, 0, 0,  0, 0,   8, 0);
    add(4'b0000,  0, 0, 1, 0,  0, 0, 0, 0,  1, 0,   8, 1);
    add(4'b0000,  0, 0, 0, 1,  0, 0, 0, 0,  0, 0,   3, 0);
    add(4'b0000,  3, 1, 0, 0,  0, 0, 1, 0,  0, 0,   0, 0);
    add(4'b0000,  0, 0, 1, 0,  0, 0, 0, 0,  0, 0,   0, 0);
    add(4'b0000,  0, 1, 0, 0,  0, 0, 0, 1,  0, 0,   0, 0);

    foreach (tbl[i]) begin
      coin_in   = tbl[i].coin;
      price     = 8'(tbl[i].price);
      vend_req  = tbl[i].vend;
      cancel    = tbl[i].cxl;
      chg_ready = tbl[i].rdy;
      tick();
      check($sformatf("vec%0d", i), got_vec(),
            pack(tbl[i].acc, tbl[i].rej, tbl[i].vok, tbl[i].vden, tbl[i].cv,
                 tbl[i].idx, tbl[i].bal, tbl[i].bsy, 1'b0));
    end
    clear_inputs();

    // asynchronous reset in the middle of a refund
    do_reset();
    coin_in = 4'b1000;
    tick();
    coin_in = 4'b0000;
    cancel  = 1'b1;
    tick();
    cancel = 1'b0;
    check_int("midchg_valid_before", chg_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_int("midchg_valid_after_rst", chg_valid, 0);
    check_int("midchg_balance_after_rst", balance, 0);
    check_int("midchg_busy_after_rst", busy, 0);
    tick();
    reset_n = 1'b1;

`ifdef COIN_TIMEOUT_EN
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      coin_in = 4'b0001;
      tick();
      coin_in = 4'b0000;
      check_int("tmo_coin_accept", coin_accept, 1);
      n = 0;
      do begin
        tick();
        n++;
      end while (!timeout_evt && n < 40);
      check_int("tmo_latency", n, T_CYC);
      check_int("tmo_chg_valid", chg_valid, 1);
      check_int("tmo_chg_idx", chg_idx, 0);
      if (pass == 0) begin
        chg_ready = 1'b1;
        tick();
        chg_ready = 1'b0;
        check_int("tmo_refund_balance", balance, 0);
        check_int("tmo_refund_busy", busy, 0);
      end else begin
        #2;
        reset_n = 1'b0;
        #1;
        check_int("tmo_rst_chg_valid", chg_valid, 0);
        check_int("tmo_rst_balance", balance, 0);
        tick();
        reset_n = 1'b1;
      end
    end
`else
    do_reset();
    coin_in = 4'b0001;
    tick();
    coin_in = 4'b0000;
    seen = 1'b0;
    repeat (3 * T_CYC) begin
      tick();
      seen = seen | timeout_evt;
    end
    check_int("no_timeout_evt", seen, 0);
    check_int("no_timeout_balance", balance, 5);
    check_int("no_timeout_busy", busy, 0);
`endif

    // randomized traffic against the reference model
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       coin_in = 4'b0000;
      else if (r < 9)  coin_in = 4'(1 << $urandom_range(0, 3));
      else             coin_in = 4'($urandom_range(0, 15));
      vend_req  = ($urandom_range(0, 9) == 0);
      cancel    = ($urandom_range(0, 24) == 0);
      chg_ready = ($urandom_range(0, 2) != 0);
      price     = 8'($urandom_range(0, 60));
      model_step(coin_in, int'(price), vend_req, cancel, chg_ready, e);
      tick();
      check($sformatf("rand%0d", cyc), got_vec(), e);
    end
    clear_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
